// File: rtl/packet_disassembler_if.sv
`default_nettype none
// ============================================================================
// packet_disassembler_if : data island slice input and rebuilt packet output
// Rev 1.0
// ============================================================================
interface packet_disassembler_if;
    logic        data_island_period;
    logic [8:0]  packet_data;
    logic [23:0] header;
    logic [55:0] sub [3:0];
    logic        packet_valid;
    logic        header_ecc_ok;
    logic [3:0]  sub_ecc_ok;
    logic [7:0]  error_count;

    modport master (
        output data_island_period, packet_data,
        input  header, sub, packet_valid, header_ecc_ok, sub_ecc_ok, error_count
    );

    modport slave (
        input  data_island_period, packet_data,
        output header, sub, packet_valid, header_ecc_ok, sub_ecc_ok, error_count
    );
endinterface
`default_nettype wire

// File: rtl/packet_disassembler.sv
`default_nettype none
// ============================================================================
// packet_disassembler : rebuilds HDMI data island packets and checks BCH ECC
// Option macro: PACKET_DISASSEMBLER_DROP_BAD_EN (drop packets with bad header)
// Rev 1.0
// ============================================================================
module packet_disassembler (
    input  wire logic            clk_pixel,
    input  wire logic            reset_n,
    packet_disassembler_if.slave bus
);
    localparam logic [7:0] c_BCH_POLY = 8'h83;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        ecc_step = (e >> 1) ^ ((e[0] ^ b) ? c_BCH_POLY : 8'h00);
    endfunction

    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hsh_q, hsh_d, w_hsh_upd;
    logic [63:0] ssh_q [4];
    logic [63:0] ssh_d [4];
    logic [63:0] w_ssh_upd [4];
    logic [7:0]  hecc_q, hecc_d;
    logic [7:0]  secc_q [4];
    logic [7:0]  secc_d [4];
    logic [23:0] header_q, header_d;
    logic [55:0] sub_q [4];
    logic [55:0] sub_d [4];
    logic        hok_q, hok_d;
    logic [3:0]  sok_q, sok_d;
    logic        pv_q, pv_d;
    logic [7:0]  ec_q, ec_d;
    logic        w_hok;
    logic [3:0]  w_sok;
    logic        w_complete;
    logic        w_deliver;

    always_comb begin
        // Shadows with the current slice merged in; on slot 31 this is the bypass
        w_hsh_upd          = hsh_q;
        w_hsh_upd[cnt_q]   = bus.packet_data[0];
        for (int i = 0; i < 4; i++) begin
            w_ssh_upd[i]                  = ssh_q[i];
            w_ssh_upd[i][{cnt_q, 1'b0}]   = bus.packet_data[1 + i];
            w_ssh_upd[i][{cnt_q, 1'b1}]   = bus.packet_data[5 + i];
            w_sok[i]                      = (secc_q[i] == w_ssh_upd[i][63:56]);
        end
        w_hok      = (hecc_q == w_hsh_upd[31:24]);
        w_complete = bus.data_island_period && (cnt_q == 5'd31);
`ifdef PACKET_DISASSEMBLER_DROP_BAD_EN
        w_deliver  = w_complete && w_hok;
`else
        w_deliver  = w_complete;
`endif
    end

    always_comb begin
        cnt_d    = 5'd0;
        hsh_d    = 32'd0;
        hecc_d   = 8'd0;
        header_d = header_q;
        hok_d    = hok_q;
        sok_d    = sok_q;
        pv_d     = 1'b0;
        ec_d     = ec_q;
        for (int i = 0; i < 4; i++) begin
            ssh_d[i]  = 64'd0;
            secc_d[i] = 8'd0;
            sub_d[i]  = sub_q[i];
        end

        // Idle or completion leaves everything cleared for the next packet
        if (bus.data_island_period && !w_complete) begin
            cnt_d  = cnt_q + 5'd1;
            hsh_d  = w_hsh_upd;
            hecc_d = (cnt_q < 5'd24) ? ecc_step(hecc_q, bus.packet_data[0]) : hecc_q;
            for (int i = 0; i < 4; i++) begin
                ssh_d[i]  = w_ssh_upd[i];
                secc_d[i] = (cnt_q < 5'd28)
                          ? ecc_step(ecc_step(secc_q[i], bus.packet_data[1 + i]),
                                     bus.packet_data[5 + i])
                          : secc_q[i];
            end
        end

        if (w_deliver) begin
            header_d = w_hsh_upd[23:0];
            hok_d    = w_hok;
            sok_d    = w_sok;
            pv_d     = 1'b1;
            for (int i = 0; i < 4; i++) begin
                sub_d[i] = w_ssh_upd[i][55:0];
            end
        end

        if (w_complete && (!w_hok || (w_sok != 4'hF)) && (ec_q != 8'hFF)) begin
            ec_d = ec_q + 8'd1;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= 5'd0;
            hsh_q    <= 32'd0;
            hecc_q   <= 8'd0;
            header_q <= 24'd0;
            hok_q    <= 1'b0;
            sok_q    <= 4'd0;
            pv_q     <= 1'b0;
            ec_q     <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                ssh_q[i]  <= 64'd0;
                secc_q[i] <= 8'd0;
                sub_q[i]  <= 56'd0;
            end
        end else begin
            cnt_q    <= cnt_d;
            hsh_q    <= hsh_d;
            hecc_q   <= hecc_d;
            header_q <= header_d;
            hok_q    <= hok_d;
            sok_q    <= sok_d;
            pv_q     <= pv_d;
            ec_q     <= ec_d;
            for (int i = 0; i < 4; i++) begin
                ssh_q[i]  <= ssh_d[i];
                secc_q[i] <= secc_d[i];
                sub_q[i]  <= sub_d[i];
            end
        end
    end

    assign bus.header        = header_q;
    assign bus.packet_valid  = pv_q;
    assign bus.header_ecc_ok = hok_q;
    assign bus.sub_ecc_ok    = sok_q;
    assign bus.error_count   = ec_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
        assign bus.sub[gi] = sub_q[gi];
    end
endmodule
`default_nettype wire

// File: tb/tb_packet_disassembler.sv
`default_nettype none
// Self-checking bench: table vectors, hand sequences and random packets
// compared every cycle against a packet-level reference model.
module tb_packet_disassembler;
    logic clk_pixel = 1'b0;
    logic reset_n;

    packet_disassembler_if bus ();

    packet_disassembler dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks = 0;
    int passes = 0;

    // Reference model state: the packet on the wire and what the DUT should show
    logic [31:0] tx_h;
    logic [63:0] tx_s [4];
    logic        want_hok;
    logic [3:0]  want_sok;
    logic        exp_pv;
    logic [23:0] m_h;
    logic [55:0] m_s [4];
    logic        m_hok;
    logic [3:0]  m_sok;
    logic [7:0]  m_ec;

    typedef struct {
        logic [23:0] h;
        logic [55:0] s0, s1, s2, s3;
        int          fw;   // -1 none, 0 header word, 1..4 subpacket 0..3
        int          fb;
        logic        hok;
        logic [3:0]  sok;
    } vec_t;

    vec_t tab [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic logic [7:0] bch(input logic [55:0] d, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int k = 0; k < n; k++) e = (e >> 1) ^ ((e[0] ^ d[k]) ? 8'h83 : 8'h00);
        return e;
    endfunction

    task automatic encode(input logic [23:0] h, input logic [55:0] s0, s1, s2, s3);
        logic [55:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        tx_h = {bch({32'h0, h}, 24), h};
        for (int i = 0; i < 4; i++) tx_s[i] = {bch(s[i], 56), s[i]};
    endtask

    task automatic flip(input int w, input int b);
        if (w == 0) tx_h[b] = ~tx_h[b];
        else if (w > 0) tx_s[w-1][b] = ~tx_s[w-1][b];
    endtask

    task automatic model_flags();
        want_hok = (bch({32'h0, tx_h[23:0]}, 24) == tx_h[31:24]);
        for (int i = 0; i < 4; i++) want_sok[i] = (bch(tx_s[i][55:0], 56) == tx_s[i][63:56]);
    endtask

    task automatic check_outputs();
        check("header", bus.header, m_h);
        for (int i = 0; i < 4; i++) check($sformatf("sub%0d", i), bus.sub[i], m_s[i]);
        check("header_ecc_ok", bus.header_ecc_ok, m_hok);
        check("sub_ecc_ok", bus.sub_ecc_ok, m_sok);
        check("error_count", bus.error_count, m_ec);
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        check("packet_valid", bus.packet_valid, exp_pv);
        check_outputs();
        exp_pv = 1'b0;
    endtask

    task automatic set_slot(input int c);
        logic [8:0] pd;
        pd[0] = tx_h[c];
        for (int i = 0; i < 4; i++) begin
            pd[1+i] = tx_s[i][2*c];
            pd[5+i] = tx_s[i][2*c+1];
        end
        bus.data_island_period = 1'b1;
        bus.packet_data        = pd;
    endtask

    task automatic send_slot(input int c);
        logic deliver;
        set_slot(c);
        if (c == 31) begin
            if ((!want_hok || want_sok != 4'hF) && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
`ifdef PACKET_DISASSEMBLER_DROP_BAD_EN
            deliver = want_hok;
`else
            deliver = 1'b1;
`endif
            if (deliver) begin
                exp_pv = 1'b1;
                m_h    = tx_h[23:0];
                for (int i = 0; i < 4; i++) m_s[i] = tx_s[i][55:0];
                m_hok  = want_hok;
                m_sok  = want_sok;
            end
        end
        tick();
    endtask

    task automatic send_packet();
        for (int c = 0; c < 32; c++) send_slot(c);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus.data_island_period = 1'b0;
            bus.packet_data        = 9'($urandom);
            tick();
        end
    endtask

    task automatic load_vec(input vec_t v);
        encode(v.h, v.s0, v.s1, v.s2, v.s3);
        flip(v.fw, v.fb);
        want_hok = v.hok;
        want_sok = v.sok;
    endtask

    task automatic load_random(input bit do_flip);
        encode(24'($urandom), {24'($urandom), 32'($urandom)}, {24'($urandom), 32'($urandom)},
               {24'($urandom), 32'($urandom)}, {24'($urandom), 32'($urandom)});
        if (do_flip) begin
            int w;
            w = $urandom_range(0, 4);
            flip(w, (w == 0) ? $urandom_range(0, 31) : $urandom_range(0, 63));
        end
        model_flags();
    endtask

    localparam logic [55:0] c_S0 = 56'h1A2B3C4D5E6F70;
    localparam logic [55:0] c_S1 = 56'h0123456789ABCD;
    localparam logic [55:0] c_S2 = 56'hFEDCBA98765432;
    localparam logic [55:0] c_S3 = 56'h5A5AA5A53C3CC3;

    initial begin
        tab[0] = '{24'h000000, 56'h0, 56'h0, 56'h0, 56'h0, -1, 0, 1'b1, 4'hF};
        tab[1] = '{24'h0D0282, c_S0, c_S1, c_S2, c_S3, -1, 0, 1'b1, 4'hF};
        tab[2] = '{24'h0D0282, c_S0, c_S1, c_S2, c_S3,  0, 5, 1'b0, 4'hF};
        tab[3] = '{24'h0D0282, c_S0, c_S1, c_S2, c_S3,  3, 40, 1'b1, 4'b1011};
        tab[4] = '{24'h0D0282, c_S0, c_S1, c_S2, c_S3,  0, 29, 1'b0, 4'hF};
        tab[5] = '{24'h0D0282, c_S0, c_S1, c_S2, c_S3,  1, 63, 1'b1, 4'b1110};
        tab[6] = '{24'h0D0282, c_S0, c_S1, c_S2, c_S3,  4, 0, 1'b1, 4'b0111};

        m_h = '0; m_hok = 1'b0; m_sok = 4'h0; m_ec = 8'h00; exp_pv = 1'b0;
        for (int i = 0; i < 4; i++) m_s[i] = '0;
        reset_n = 1'b0;
        bus.data_island_period = 1'b0;
        bus.packet_data        = 9'h0;
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Table vectors, each followed by an idle gap
        for (int t = 0; t < 7; t++) begin
            load_vec(tab[t]);
            send_packet();
            idle(3);
        end

        // Island dropped at slot 17, then a full packet; outputs hold meanwhile
        load_vec(tab[1]);
        tx_h[23:0] = 24'hABCDEF;
        for (int c = 0; c < 17; c++) send_slot(c);
        idle(4);
        load_vec(tab[5]);
        send_packet();
        idle(2);

        // Three back-to-back packets in one continuous island
        for (int p = 0; p < 3; p++) begin
            load_random(1'b0);
            send_packet();
        end
        idle(2);

        // Reset in the middle of slot 10
        load_vec(tab[1]);
        for (int c = 0; c < 10; c++) send_slot(c);
        set_slot(10);
        #2 reset_n = 1'b0;
        #1;
        m_h = '0; m_hok = 1'b0; m_sok = 4'h0; m_ec = 8'h00;
        for (int i = 0; i < 4; i++) m_s[i] = '0;
        check("packet_valid_in_reset", bus.packet_valid, 1'b0);
        check_outputs();
        tick();
        reset_n = 1'b1;
        for (int c = 11; c < 20; c++) send_slot(c);
        idle(1);
        load_vec(tab[3]);
        send_packet();
        idle(2);

        // Randomized packets with occasional corruption, gaps and aborts
        for (int r = 0; r < 40; r++) begin
            load_random($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 5) == 0) begin
                int stop;
                stop = $urandom_range(1, 30);
                for (int c = 0; c < stop; c++) send_slot(c);
                idle(1);
            end else begin
                send_packet();
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        end
        idle(2);

        // Corrupted packets until the error counter saturates
        load_vec(tab[2]);
        for (int p = 0; p < 256; p++) send_packet();
        idle(2);
        check("error_count_saturated", bus.error_count, 8'hFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
